seno_escalonador: RTL and testbench
===================================

# seno_escalonador

Scheduler that shares one single-port sine ROM among several channels. Each channel is a phase-accumulator DDS with its own step word and enable. On every sample tick the block advances all phases and reads the ROM once per channel in round-robin order. It then publishes all channel samples together with a one-cycle valid strobe. It sits between the register/config bus and the external `seno_rom` lookup table, and drives the DAC interface.

## Interface
- `CLOCK_IN`, 50\*10\*\*6: input clock frequency in Hz.
- `TAXA_AMOSTRA`, 10\*10\*\*6: sample rate in Hz. DIVISOR = CLOCK_IN/TAXA_AMOSTRA.
- `CANAIS`, 2: number of channels, 1..8.
- `BITS_FASE`, 24: phase accumulator width.
- `BITS_ENDERECO`, 12: ROM address width. The ROM depth is 2\*\*BITS_ENDERECO.
- `BITS_DADO`, 12: ROM sample width.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: configuration write accepted when high together with `cfg_valid`.
- `cfg_canal` in $clog2(CANAIS) (minimum 1): target channel.
- `cfg_passo` in BITS_FASE: phase step word.
- `cfg_en` in 1: channel enable.
- `rom_rd` out 1: ROM read strobe.
- `rom_addr` out BITS_ENDERECO: ROM address.
- `rom_data` in BITS_DADO: ROM data, valid one cycle after `rom_rd`.
- `saida` out CANAIS\*BITS_DADO: packed samples, channel 0 in the LSBs.
- `saida_valida` out 1: one-cycle pulse when `saida` updates.
- `sinc` in 1: phase synchronisation. Present only with SENO_SINC_EN.

## Operation
- Divider counter:
  - Counts 0..DIVISOR-1.
  - The tick is the cycle where the counter equals DIVISOR-1.
  - Elaboration error if DIVISOR < CANAIS+2.
- Configuration:
  - Each channel has shadow registers `passo_sh` and `en_sh`.
  - A handshake (`cfg_valid` && `cfg_ready`) writes the shadow registers of `cfg_canal`.
  - `cfg_ready` = 1 every cycle except tick cycles.
  - A write is never dropped: the master holds `cfg_valid` until it sees `cfg_ready`.
  - `cfg_canal` ≥ CANAIS is accepted and ignored.
- At each tick, for each channel:
  - If `en_sh` = 1: `fase <= fase + passo_sh`, modulo 2\*\*BITS_FASE, with wrap-around.
  - If `en_sh` = 0: `fase <= 0`.
  - Shadow values take effect at the first tick after the write.
- ROM address: `rom_addr` = `fase[BITS_FASE-1 -: BITS_ENDERECO]` of the channel being served.
- FSM states:
  - OCIOSO: waits for the tick, then goes to LEITURA.
  - LEITURA: one cycle per channel k = 0..CANAIS-1.
    - `rom_rd` = 1 and `rom_addr` = address of channel k.
    - `rom_data` for channel k-1 is captured into buffer k-1.
    - After k = CANAIS-1, go to ESPERA.
  - ESPERA: captures the data of the last channel, then goes to PUBLICA.
  - PUBLICA: copies the buffer into `saida`, asserts `saida_valida`, returns to OCIOSO.
- Disabled channel: its `saida` slot is forced to 0 at PUBLICA. Its ROM slot is still read, so the schedule stays fixed.
- `passo` = 0 with the channel enabled: the output stays constant at the current phase.
- Reset values:
  - Counter, all `fase`, shadows and buffers: 0.
  - FSM: OCIOSO.
  - `saida`: 0, `saida_valida`: 0, `rom_rd`: 0, `rom_addr`: 0.
  - `cfg_ready`: 1.
- Reset asserted mid-sequence aborts immediately. The first tick after release is DIVISOR cycles later.

## Timing
- Tick at cycle T:
  - LEITURA occupies T+1..T+CANAIS.
  - ESPERA is T+CANAIS+1.
  - `saida` and `saida_valida` are registered and visible at T+CANAIS+2.
- Latency from tick to `saida_valida` = CANAIS+2 cycles.
- One `saida_valida` pulse every DIVISOR cycles in steady state.
- ROM read latency is fixed at 1 cycle.
- `saida` holds its value between pulses.

## Configuration
- `SENO_SINC_EN` defined:
  - The `sinc` port exists.
  - `sinc` high on any cycle sets a pending flag.
  - At the next tick all phases load 0 instead of incrementing, and the flag clears.
  - A `sinc` arriving on the tick cycle itself applies to that tick.
- `SENO_SINC_EN` undefined: no port and no flag. Phases only increment.

## Structure
- Package `seno_pkg` holds:
  - The FSM state enum (OCIOSO, LEITURA, ESPERA, PUBLICA).
  - The address-extraction function.
  - The DIVISOR computation.
- Sub-module `seno_acumulador`, one instance per channel. It contains:
  - Shadow registers.
  - The phase register.
  - The increment/clear logic, driven by the tick and the `sinc` flag.
- The scheduler FSM, buffers and output registers live in the top module.
- `seno_rom` is instantiated outside this block.

## Test plan
- Reset with defaults (DIVISOR=5, CANAIS=2): `saida` = 0, `saida_valida` = 0, `rom_rd` = 0, `cfg_ready` = 1.
- Channel 0 with `passo` = 2\*\*12 and enabled, channel 1 disabled:
  - `rom_addr` for channel 0 is 1, 2, 3... on successive ticks.
  - `saida[23:12]` = 0.
  - `saida_valida` arrives 4 cycles after each tick, with a period of 5 cycles.
- Channel 1 with `passo` = 2\*\*24-2\*\*12:
  - The address decrements 0 → 4095 → 4094.
  - Checks phase wrap-around.
- `cfg_valid` held high across a tick: `cfg_ready` = 0 on the tick cycle, and the write completes on the next cycle.
- `rst_n` pulsed during LEITURA: all outputs are 0 asynchronously, and the next `saida_valida` occurs 5+4 cycles after release.
- With SENO_SINC_EN, `sinc` pulsed mid-period with both channels running: the next published samples equal `rom[0]` for both channels.

Source files
------------

// File: rtl/seno_pkg.sv
// seno_pkg: FSM states, sample-rate divisor and ROM address helper for the sine scheduler
package seno_pkg;
  typedef enum logic [1:0] {OCIOSO, LEITURA, ESPERA, PUBLICA} estado_t;
  function automatic int divisor(input int clock_in, input int taxa);
    return clock_in / taxa;
  endfunction
  // Upper BITS_END bits of the phase; the caller truncates to the ROM address width
  function automatic logic [31:0] endereco(input logic [63:0] fase, input int bits_fase, input int bits_end);
    return 32'(fase >> (bits_fase - bits_end));
  endfunction
endpackage

// File: rtl/seno_acumulador.sv
// seno_acumulador: per-channel shadow step/enable and DDS phase register
// Shadows load on a config handshake and only reach the phase on the next tick.
module seno_acumulador #(
  parameter int BITS_FASE = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic                 limpa_i,
  input  logic                 wr_i,
  input  logic [BITS_FASE-1:0] passo_i,
  input  logic                 en_i,
  output logic [BITS_FASE-1:0] fase_o,
  output logic                 en_o
);
  logic [BITS_FASE-1:0] passo_q, fase_q, fase_d;
  logic en_sh_q, en_q;
  assign fase_d = (limpa_i || !en_sh_q) ? '0 : fase_q + passo_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      passo_q <= '0;
      en_sh_q <= 1'b0;
      fase_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      if (wr_i) begin
        passo_q <= passo_i;
        en_sh_q <= en_i;
      end
      if (tick_i) begin
        fase_q <= fase_d;
        en_q   <= en_sh_q;
      end
    end
  end
  assign fase_o = fase_q;
  assign en_o   = en_q;
endmodule

// File: rtl/seno_escalonador.sv
// seno_escalonador: round-robin sharing of one sine ROM among CANAIS DDS channels
// Optional macro SENO_SINC_EN adds the sinc port that zeroes all phases at the next tick.
module seno_escalonador
  import seno_pkg::*;
#(
  parameter int CLOCK_IN      = 50_000_000,
  parameter int TAXA_AMOSTRA  = 10_000_000,
  parameter int CANAIS        = 2,
  parameter int BITS_FASE     = 24,
  parameter int BITS_ENDERECO = 12,
  parameter int BITS_DADO     = 12
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               cfg_valid,
  output logic                                               cfg_ready,
  input  logic [(CANAIS > 1 ? $clog2(CANAIS) : 1)-1:0]       cfg_canal,
  input  logic [BITS_FASE-1:0]                               cfg_passo,
  input  logic                                               cfg_en,
  output logic                                               rom_rd,
  output logic [BITS_ENDERECO-1:0]                           rom_addr,
  input  logic [BITS_DADO-1:0]                               rom_data,
  output logic [CANAIS*BITS_DADO-1:0]                        saida,
  output logic                                               saida_valida
`ifdef SENO_SINC_EN
  ,
  input  logic                                               sinc
`endif
);
  localparam int DIVISOR = divisor(CLOCK_IN, TAXA_AMOSTRA);
  localparam int CW = CANAIS > 1 ? $clog2(CANAIS) : 1;
  localparam int DW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;

  if (DIVISOR < CANAIS + 2) begin : g_divisor_curto
    $error("seno_escalonador: DIVISOR must be at least CANAIS+2");
  end

  logic [DW-1:0] cnt_q, cnt_d;
  logic tick, limpa;
  estado_t estado_q, estado_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [BITS_FASE-1:0] fase [CANAIS];
  logic [CANAIS-1:0] en_ef;
  logic [BITS_DADO-1:0] buf_q [CANAIS];
  logic [CANAIS*BITS_DADO-1:0] saida_q, saida_d;

  assign tick      = cnt_q == DW'(DIVISOR - 1);
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign cfg_ready = !tick;

`ifdef SENO_SINC_EN
  logic sinc_q;
  assign limpa = sinc_q | sinc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sinc_q <= 1'b0;
    else        sinc_q <= tick ? 1'b0 : limpa;
  end
`else
  assign limpa = 1'b0;
`endif

  for (genvar k = 0; k < CANAIS; k++) begin : g_canal
    seno_acumulador #(.BITS_FASE(BITS_FASE)) u_acum (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick),
      .limpa_i (limpa),
      .wr_i    (cfg_valid && cfg_ready && cfg_canal == CW'(k)),
      .passo_i (cfg_passo),
      .en_i    (cfg_en),
      .fase_o  (fase[k]),
      .en_o    (en_ef[k])
    );
  end

  always_comb begin
    estado_d = estado_q;
    idx_d    = estado_q == LEITURA ? idx_q + 1'b1 : '0;
    rom_rd   = 1'b0;
    rom_addr = '0;
    case (estado_q)
      OCIOSO:  estado_d = tick ? LEITURA : OCIOSO;
      LEITURA: begin
        rom_rd   = 1'b1;
        rom_addr = BITS_ENDERECO'(endereco(64'(fase[idx_q]), BITS_FASE, BITS_ENDERECO));
        estado_d = idx_q == CW'(CANAIS - 1) ? ESPERA : LEITURA;
      end
      ESPERA:  estado_d = PUBLICA;
      PUBLICA: estado_d = tick ? LEITURA : OCIOSO;
    endcase
  end

  // The last channel's word is still on rom_data during ESPERA, so it bypasses its buffer
  always_comb begin
    saida_d = '0;
    for (int k = 0; k < CANAIS; k++)
      saida_d[k*BITS_DADO +: BITS_DADO] = !en_ef[k] ? '0 : (k == CANAIS - 1) ? rom_data : buf_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      estado_q <= OCIOSO;
      idx_q    <= '0;
      saida_q  <= '0;
      for (int k = 0; k < CANAIS; k++) buf_q[k] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      estado_q <= estado_d;
      idx_q    <= idx_d;
      if (estado_q == LEITURA && idx_q != '0) buf_q[idx_q - 1'b1] <= rom_data;
      if (estado_q == ESPERA) begin
        buf_q[CANAIS-1] <= rom_data;
        saida_q         <= saida_d;
      end
    end
  end

  assign saida        = saida_q;
  assign saida_valida = estado_q == PUBLICA;
endmodule

// File: tb/tb_seno_escalonador.sv
// tb_seno_escalonador: randomized and directed checks of seno_escalonador against a timeline model
module tb_seno_escalonador;
  localparam int CANAIS = 2;
  localparam int DIV = 5;

  logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, cfg_en = 1'b0, sinc = 1'b0;
  logic [0:0] cfg_canal = '0;
  logic [23:0] cfg_passo = '0;
  logic cfg_ready, rom_rd, saida_valida;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [23:0] saida;
  int chk_cnt = 0, pass_cnt = 0;

  always #5 clk = ~clk;

  seno_escalonador dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_canal    (cfg_canal),
    .cfg_passo    (cfg_passo),
    .cfg_en       (cfg_en),
    .rom_rd       (rom_rd),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .saida        (saida),
    .saida_valida (saida_valida)
`ifdef SENO_SINC_EN
    ,
    .sinc         (sinc)
`endif
  );

  // Bijective stand-in for the sine table; rom_fn(0) is non-zero so masking is visible
  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    return (a * 12'd37) ^ 12'h5A5;
  endfunction

  always @(posedge clk) if (rom_rd) rom_data <= rom_fn(rom_addr);

  // Reference model: phases, shadows and a timeline counter n (edges since the last tick)
  int c, n;
  bit tk, sn;
  logic [23:0] ph [CANAIS];
  logic [23:0] sp [CANAIS];
  bit se [CANAIS];
  bit ee [CANAIS];
  logic [23:0] pend, exp_saida;
  bit exp_rd, exp_valid, exp_ready;
  logic [11:0] exp_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = 0; n = -1; sn = 0; pend = '0;
      for (int k = 0; k < CANAIS; k++) begin ph[k] = '0; sp[k] = '0; se[k] = 0; ee[k] = 0; end
      exp_saida = '0; exp_rd = 0; exp_addr = '0; exp_valid = 0; exp_ready = 1;
    end else begin
      tk = (c == DIV - 1);
      if (cfg_valid && !tk && int'(cfg_canal) < CANAIS) begin
        sp[cfg_canal] = cfg_passo;
        se[cfg_canal] = cfg_en;
      end
      if (tk) begin
        for (int k = 0; k < CANAIS; k++) begin
          ph[k] = (sn || sinc || !se[k]) ? 24'd0 : ph[k] + sp[k];
          ee[k] = se[k];
          pend[k*12 +: 12] = ee[k] ? rom_fn(ph[k][23:12]) : 12'd0;
        end
        sn = 0; n = 0;
      end else begin
        sn = sn | sinc;
        if (n >= 0) n++;
      end
      c = tk ? 0 : c + 1;
      exp_rd = n >= 0 && n < CANAIS;
      exp_addr = exp_rd ? ph[n][23:12] : 12'd0;
      exp_valid = n == CANAIS + 1;
      if (exp_valid) exp_saida = pend;
      exp_ready = c != DIV - 1;
    end
  end

  // Recorder: per-channel ROM addresses, tick cycles, publish cycles and samples
  int cyc = 0, slot = 0;
  logic prev_rd = 1'b0;
  int ch0_q[$], ch1_q[$], tq[$], vq[$];
  logic [23:0] sq[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rom_rd) begin
      slot = prev_rd ? slot + 1 : 0;
      if (slot == 0) ch0_q.push_back(int'(rom_addr));
      else if (slot == 1) ch1_q.push_back(int'(rom_addr));
    end
    prev_rd = rom_rd;
    if (!cfg_ready) tq.push_back(cyc);
    if (saida_valida) begin vq.push_back(cyc); sq.push_back(saida); end
  end

  task automatic cfg_write(input logic [0:0] ca, input logic [23:0] pa, input logic en);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_canal = ca; cfg_passo = pa; cfg_en = en;
    for (int i = 0; i < 10 && !cfg_ready; i++) @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (saida !== 24'd0) $display("FAIL reset_saida got=%h exp=0", saida); else pass_cnt++;
    chk_cnt++; if (saida_valida !== 1'b0) $display("FAIL reset_valida got=%b exp=0", saida_valida); else pass_cnt++;
    chk_cnt++; if (rom_rd !== 1'b0) $display("FAIL reset_rom_rd got=%b exp=0", rom_rd); else pass_cnt++;
    chk_cnt++; if (rom_addr !== 12'd0) $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); else pass_cnt++;
    chk_cnt++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); else pass_cnt++;
    rst_n = 1'b1;
    ch0_q.delete(); ch1_q.delete(); tq.delete(); vq.delete(); sq.delete();
  endtask

  task automatic test_ramp;
    cfg_write(1'b0, 24'd4096, 1'b1);
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (ch0_q.size() < 3 || tq.size() < 4 || vq.size() < 3)
      $display("FAIL ramp_counts got=%0d/%0d/%0d exp>=3/4/3", ch0_q.size(), tq.size(), vq.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        chk_cnt++; if (ch0_q[i] != i + 1) $display("FAIL ramp_addr%0d got=%0d exp=%0d", i, ch0_q[i], i + 1); else pass_cnt++;
        chk_cnt++; if (vq[i] - tq[i] != CANAIS + 2) $display("FAIL ramp_latency%0d got=%0d exp=%0d", i, vq[i] - tq[i], CANAIS + 2); else pass_cnt++;
        chk_cnt++; if (sq[i][23:12] !== 12'd0) $display("FAIL ramp_ch1_off%0d got=%h exp=0", i, sq[i][23:12]); else pass_cnt++;
        chk_cnt++; if (sq[i][11:0] !== rom_fn(12'(i + 1))) $display("FAIL ramp_ch0_data%0d got=%h exp=%h", i, sq[i][11:0], rom_fn(12'(i + 1))); else pass_cnt++;
      end
      for (int i = 0; i < 2; i++) begin
        chk_cnt++; if (vq[i+1] - vq[i] != DIV) $display("FAIL ramp_period%0d got=%0d exp=%0d", i, vq[i+1] - vq[i], DIV); else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap;
    int k;
    for (k = 0; k < 20 && cfg_ready; k++) @(negedge clk);
    ch1_q.delete();
    cfg_write(1'b1, 24'hFFF000, 1'b1);
    repeat (17) @(negedge clk);
    chk_cnt++;
    if (ch1_q.size() < 4) $display("FAIL wrap_count got=%0d exp>=4", ch1_q.size());
    else begin
      pass_cnt++;
      chk_cnt++; if (ch1_q[0] != 0) $display("FAIL wrap_addr0 got=%0d exp=0", ch1_q[0]); else pass_cnt++;
      chk_cnt++; if (ch1_q[1] != 4095) $display("FAIL wrap_addr1 got=%0d exp=4095", ch1_q[1]); else pass_cnt++;
      chk_cnt++; if (ch1_q[2] != 4094) $display("FAIL wrap_addr2 got=%0d exp=4094", ch1_q[2]); else pass_cnt++;
      chk_cnt++; if (ch1_q[3] != 4093) $display("FAIL wrap_addr3 got=%0d exp=4093", ch1_q[3]); else pass_cnt++;
    end
  endtask

  task automatic test_cfg_across_tick;
    logic [11:0] e;
    int k;
    for (k = 0; k < 20 && exp_ready; k++) @(negedge clk);
    e = ph[0][23:12] + (se[0] ? sp[0][23:12] : 12'd0);
    ch0_q.delete();
    cfg_valid = 1'b1; cfg_canal = 1'b0; cfg_passo = 24'd0; cfg_en = 1'b1;
    chk_cnt++; if (cfg_ready !== 1'b0) $display("FAIL tick_ready got=%b exp=0", cfg_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (cfg_ready !== 1'b1) $display("FAIL after_tick_ready got=%b exp=1", cfg_ready); else pass_cnt++;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk_cnt++;
    if (ch0_q.size() < 3) $display("FAIL hold_count got=%0d exp>=3", ch0_q.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        chk_cnt++; if (ch0_q[i] != int'(e)) $display("FAIL hold_addr%0d got=%0d exp=%0d", i, ch0_q[i], e); else pass_cnt++;
      end
    end
  endtask

`ifdef SENO_SINC_EN
  task automatic test_sinc;
    int k;
    cfg_write(1'b0, 24'd12288, 1'b1);
    cfg_write(1'b1, 24'd12345, 1'b1);
    for (k = 0; k < 12 && !saida_valida; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    sinc = 1'b1;
    @(negedge clk);
    sinc = 1'b0;
    for (k = 0; k < 12 && !saida_valida; k++) @(negedge clk);
    chk_cnt++; if (saida !== {rom_fn(12'd0), rom_fn(12'd0)}) $display("FAIL sinc_zero got=%h exp=%h", saida, {rom_fn(12'd0), rom_fn(12'd0)}); else pass_cnt++;
    @(negedge clk);
    for (k = 0; k < 12 && !saida_valida; k++) @(negedge clk);
    chk_cnt++; if (saida !== {rom_fn(12'd3), rom_fn(12'd3)}) $display("FAIL sinc_next got=%h exp=%h", saida, {rom_fn(12'd3), rom_fn(12'd3)}); else pass_cnt++;
  endtask
`endif

  task automatic test_random;
    bit hs = 0;
    int r;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk_cnt++; if (cfg_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, exp_ready); else pass_cnt++;
      chk_cnt++; if (rom_rd !== exp_rd) $display("FAIL rnd_rom_rd cyc=%0d got=%b exp=%b", cyc, rom_rd, exp_rd); else pass_cnt++;
      chk_cnt++; if (rom_addr !== exp_addr) $display("FAIL rnd_rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, exp_addr); else pass_cnt++;
      chk_cnt++; if (saida_valida !== exp_valid) $display("FAIL rnd_valida cyc=%0d got=%b exp=%b", cyc, saida_valida, exp_valid); else pass_cnt++;
      chk_cnt++; if (saida !== exp_saida) $display("FAIL rnd_saida cyc=%0d got=%h exp=%h", cyc, saida, exp_saida); else pass_cnt++;
      if (cfg_valid && hs) cfg_valid = 1'b0;
      if (!cfg_valid && $urandom_range(2) == 0) begin
        cfg_valid = 1'b1;
        cfg_canal = 1'($urandom_range(1));
        r = $urandom_range(3);
        cfg_passo = r == 0 ? 24'd0 : r == 1 ? 24'd4096 : r == 2 ? 24'hFFF000 : 24'($urandom);
        cfg_en = $urandom_range(3) != 0;
      end
      hs = cfg_valid && cfg_ready;
`ifdef SENO_SINC_EN
      sinc = $urandom_range(15) == 0;
`endif
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    sinc = 1'b0;
  endtask

  task automatic test_reset_mid;
    int k, got;
    for (k = 0; k < 20 && !rom_rd; k++) @(negedge clk);
    chk_cnt++; if (!rom_rd) $display("FAIL mid_find_leitura got=0 exp=1"); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (rom_rd !== 1'b0) $display("FAIL mid_rom_rd got=%b exp=0", rom_rd); else pass_cnt++;
    chk_cnt++; if (rom_addr !== 12'd0) $display("FAIL mid_rom_addr got=%h exp=0", rom_addr); else pass_cnt++;
    chk_cnt++; if (saida !== 24'd0) $display("FAIL mid_saida got=%h exp=0", saida); else pass_cnt++;
    chk_cnt++; if (saida_valida !== 1'b0) $display("FAIL mid_valida got=%b exp=0", saida_valida); else pass_cnt++;
    chk_cnt++; if (cfg_ready !== 1'b1) $display("FAIL mid_cfg_ready got=%b exp=1", cfg_ready); else pass_cnt++;
    #2 rst_n = 1'b1;
    got = -1;
    for (int i = 1; i <= 40 && got < 0; i++) begin
      @(posedge clk);
      #1;
      if (saida_valida) got = i;
    end
    // Release cycle is cycle 1, tick in cycle DIV, publish CANAIS+2 cycles later
    chk_cnt++; if (got != DIV - 1 + CANAIS + 2) $display("FAIL mid_first_valid got=%0d exp=%0d", got, DIV - 1 + CANAIS + 2); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_wrap;
    test_cfg_across_tick;
`ifdef SENO_SINC_EN
    test_sinc;
`endif
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
